// File: rtl/cache_pkg.sv
// Shared definitions for the 2-way read-only cache controller.
package cache_pkg;

  localparam int TAG_WIDTH_DEF  = 13;
  localparam int SET_WIDTH_DEF  = 8;
  localparam int DATA_WIDTH_DEF = 16;
  localparam int CNT_WIDTH      = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_COMPARE   = 2'd1,
    ST_MISS_REQ  = 2'd2,
    ST_MISS_WAIT = 2'd3
  } state_e;

  // Saturating increment for the statistics counters.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    logic [CNT_WIDTH-1:0] one;
    one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    return (v == {CNT_WIDTH{1'b1}}) ? v : v + one;
  endfunction

endpackage

// File: rtl/cache_lru_valid.sv
// Valid and LRU bookkeeping for both ways, plus victim selection.
module cache_lru_valid
  import cache_pkg::*;
#(
  parameter int SET_WIDTH = SET_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_clear,
  input  logic [SET_WIDTH-1:0] i_set,
  input  logic                 i_upd,
  input  logic                 i_upd_way,
  input  logic                 i_fill,
  output logic [1:0]           o_valid,
  output logic                 o_victim
);

  localparam int NSETS = 1 << SET_WIDTH;

  logic [NSETS-1:0] r_valid0;
  logic [NSETS-1:0] r_valid1;
  logic [NSETS-1:0] r_lru;

  // Valid/LRU arrays: cleared by reset or flush, updated on hit or fill.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_valid0 <= '0;
      r_valid1 <= '0;
      r_lru    <= '0;
    end else if (i_upd) begin
      // LRU always points at the way that was not just used
      r_lru[i_set] <= ~i_upd_way;
      if (i_fill && i_upd_way) begin
        r_valid1[i_set] <= 1'b1;
      end else if (i_fill) begin
        r_valid0[i_set] <= 1'b1;
      end
    end
  end

  assign o_valid  = {r_valid1[i_set], r_valid0[i_set]};
  // First invalid way wins (way 0 first); otherwise follow LRU
  assign o_victim = (!r_valid0[i_set]) ? 1'b0 :
                    (!r_valid1[i_set]) ? 1'b1 : r_lru[i_set];

endmodule

// File: rtl/cache_ctrl.sv
// 2-way set-associative read-only cache controller; way arrays live outside.
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int TAG_WIDTH  = TAG_WIDTH_DEF,
  parameter int SET_WIDTH  = SET_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = TAG_WIDTH + SET_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_hit,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_resp_data,
  output logic                  way_rd_en,
  output logic [SET_WIDTH-1:0]  way_set,
  output logic [TAG_WIDTH-1:0]  way_tag_wr,
  output logic [DATA_WIDTH-1:0] way_data_wr,
  output logic [1:0]            way_we_tag,
  output logic [1:0]            way_we_data,
  input  logic [TAG_WIDTH-1:0]  tag_rd_0,
  input  logic [TAG_WIDTH-1:0]  tag_rd_1,
  input  logic [DATA_WIDTH-1:0] data_rd_0,
  input  logic [DATA_WIDTH-1:0] data_rd_1,
  input  logic                  flush,
  output logic [15:0]           hit_count,
  output logic [15:0]           miss_count
);

  state_e                r_state;
  state_e                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_victim;
  logic                  r_resp_valid;
  logic [DATA_WIDTH-1:0] r_resp_data;
  logic                  r_resp_hit;
  logic [CNT_WIDTH-1:0]  r_hit_count;
  logic [CNT_WIDTH-1:0]  r_miss_count;

  logic [TAG_WIDTH-1:0]  w_tag;
  logic [SET_WIDTH-1:0]  w_set;
  logic [1:0]            w_valid;
  logic                  w_victim;
  logic                  w_hit0;
  logic                  w_hit1;
  logic                  w_accept;
  logic                  w_hit_cmp;
  logic                  w_miss_cmp;
  logic                  w_clear;
  logic                  w_upd;
  logic                  w_upd_way;
  logic                  w_fill;

  assign w_tag  = r_addr[ADDR_WIDTH-1:SET_WIDTH];
  // The set index comes straight from the request in IDLE so the ways read in the accept cycle
  assign w_set  = (r_state == ST_IDLE) ? req_addr[SET_WIDTH-1:0] : r_addr[SET_WIDTH-1:0];
  assign w_hit0 = w_valid[0] && (tag_rd_0 == w_tag);
  assign w_hit1 = w_valid[1] && (tag_rd_1 == w_tag);

  cache_lru_valid #(.SET_WIDTH(SET_WIDTH)) u_lru_valid (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (w_clear),
    .i_set     (w_set),
    .i_upd     (w_upd),
    .i_upd_way (w_upd_way),
    .i_fill    (w_fill),
    .o_valid   (w_valid),
    .o_victim  (w_victim)
  );

  assign way_set     = w_set;
  assign way_tag_wr  = w_tag;
  assign way_data_wr = mem_resp_data;
  assign mem_addr    = r_addr;
  assign resp_valid  = r_resp_valid;
  assign resp_data   = r_resp_data;
  assign resp_hit    = r_resp_hit;
  assign hit_count   = r_hit_count;
  assign miss_count  = r_miss_count;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and per-cycle strobes; everything is held low while reset is asserted.
  always_comb begin
    w_state_nxt   = r_state;
    req_ready     = 1'b0;
    way_rd_en     = 1'b0;
    way_we_tag    = 2'b00;
    way_we_data   = 2'b00;
    mem_req_valid = 1'b0;
    w_accept      = 1'b0;
    w_hit_cmp     = 1'b0;
    w_miss_cmp    = 1'b0;
    w_clear       = 1'b0;
    w_upd         = 1'b0;
    w_upd_way     = 1'b0;
    w_fill        = 1'b0;
    if (reset) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (flush) begin
            w_clear = 1'b1;
          end else begin
            req_ready = 1'b1;
            if (req_valid) begin
              way_rd_en   = 1'b1;
              w_accept    = 1'b1;
              w_state_nxt = ST_COMPARE;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end
        end
        ST_COMPARE: begin
          if (w_hit0 || w_hit1) begin
            w_hit_cmp   = 1'b1;
            w_upd       = 1'b1;
            w_upd_way   = ~w_hit0;
            w_state_nxt = ST_IDLE;
          end else begin
            w_miss_cmp  = 1'b1;
            w_state_nxt = ST_MISS_REQ;
          end
        end
        ST_MISS_REQ: begin
          mem_req_valid = 1'b1;
          if (mem_req_ready) begin
            w_state_nxt = ST_MISS_WAIT;
          end else begin
            w_state_nxt = ST_MISS_REQ;
          end
        end
        ST_MISS_WAIT: begin
          if (mem_resp_valid) begin
            way_we_tag  = r_victim ? 2'b10 : 2'b01;
            way_we_data = r_victim ? 2'b10 : 2'b01;
            w_upd       = 1'b1;
            w_upd_way   = r_victim;
            w_fill      = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_MISS_WAIT;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Request latch, victim latch, registered response and saturating statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr       <= '0;
      r_victim     <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_resp_hit   <= 1'b0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      if (w_accept) begin
        r_addr <= req_addr;
      end
      if (w_miss_cmp) begin
        r_victim     <= w_victim;
        r_miss_count <= sat_inc(r_miss_count);
      end
      if (w_hit_cmp) begin
        r_resp_valid <= 1'b1;
        r_resp_data  <= w_hit0 ? data_rd_0 : data_rd_1;
        r_resp_hit   <= 1'b1;
        r_hit_count  <= sat_inc(r_hit_count);
      end
      if (w_fill) begin
        r_resp_valid <= 1'b1;
        r_resp_data  <= mem_resp_data;
        r_resp_hit   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Scoreboard bench for cache_ctrl with behavioural way arrays and memory.
module tb_cache_ctrl;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [20:0] req_addr;
  logic        resp_valid;
  logic [15:0] resp_data;
  logic        resp_hit;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [20:0] mem_addr;
  logic        mem_resp_valid;
  logic [15:0] mem_resp_data;
  logic        way_rd_en;
  logic [7:0]  way_set;
  logic [12:0] way_tag_wr;
  logic [15:0] way_data_wr;
  logic [1:0]  way_we_tag;
  logic [1:0]  way_we_data;
  logic [12:0] tag_rd_0, tag_rd_1;
  logic [15:0] data_rd_0, data_rd_1;
  logic        flush;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  cache_ctrl dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_hit(resp_hit), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .way_rd_en(way_rd_en), .way_set(way_set), .way_tag_wr(way_tag_wr),
    .way_data_wr(way_data_wr), .way_we_tag(way_we_tag), .way_we_data(way_we_data),
    .tag_rd_0(tag_rd_0), .tag_rd_1(tag_rd_1), .data_rd_0(data_rd_0), .data_rd_1(data_rd_1),
    .flush(flush), .hit_count(hit_count), .miss_count(miss_count)
  );

  typedef struct {
    logic [15:0] data;
    logic        hit;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   hs_count = 0;
  logic [20:0] hs_addr = '0;
  int   we_count = 0;
  logic [1:0] last_we_tag = 2'b00;
  logic [1:0] last_we_data = 2'b00;
  logic [7:0] last_we_set = 8'h00;
  int   stall_cfg = 0;

  logic [12:0] tag_mem0 [0:255];
  logic [12:0] tag_mem1 [0:255];
  logic [15:0] dat_mem0 [0:255];
  logic [15:0] dat_mem1 [0:255];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural way arrays: one-cycle read latency, write on enables.
  always @(posedge clk) begin
    if (way_rd_en) begin
      tag_rd_0  <= tag_mem0[way_set];
      tag_rd_1  <= tag_mem1[way_set];
      data_rd_0 <= dat_mem0[way_set];
      data_rd_1 <= dat_mem1[way_set];
    end
    if (way_we_tag[0])  tag_mem0[way_set] <= way_tag_wr;
    if (way_we_tag[1])  tag_mem1[way_set] <= way_tag_wr;
    if (way_we_data[0]) dat_mem0[way_set] <= way_data_wr;
    if (way_we_data[1]) dat_mem1[way_set] <= way_data_wr;
    if ((|way_we_tag) || (|way_we_data)) begin
      last_we_tag  <= way_we_tag;
      last_we_data <= way_we_data;
      last_we_set  <= way_set;
      we_count     <= we_count + 1;
    end
  end

  // Handshake tracker for the memory port.
  always @(posedge clk) begin
    if (mem_req_valid && mem_req_ready) begin
      hs_count <= hs_count + 1;
      hs_addr  <= mem_addr;
    end
  end

  function automatic logic [15:0] mem_data(input logic [20:0] a);
    case (a)
      21'h00123: return 16'hBEEF;
      21'h00223: return 16'h1111;
      21'h00323: return 16'h2222;
      default:   return a[15:0] ^ 16'h5A5A;
    endcase
  endfunction

  // Memory model: ready after stall_cfg waiting cycles, response the cycle after handshake.
  initial begin
    int served;
    int stall_cnt;
    served = 0;
    stall_cnt = 0;
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data = 16'h0000;
    forever begin
      @(negedge clk);
      if (hs_count != served) begin
        served = hs_count;
        mem_resp_valid = 1'b1;
        mem_resp_data = mem_data(hs_addr);
      end else begin
        mem_resp_valid = 1'b0;
      end
      if (mem_req_valid) begin
        if (stall_cnt >= stall_cfg) begin
          mem_req_ready = 1'b1;
        end else begin
          mem_req_ready = 1'b0;
          stall_cnt++;
        end
      end else begin
        mem_req_ready = 1'b0;
        stall_cnt = 0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Response monitor: every resp_valid pulse must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (resp_valid) begin
        if (q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_resp: got data 0x%0h hit %0b, required no response", resp_data, resp_hit);
        end else begin
          e = q.pop_front();
          check("resp_data", {16'h0, resp_data}, {16'h0, e.data});
          check("resp_hit", {31'h0, resp_hit}, {31'h0, e.hit});
          if (e.cyc >= 0) check("hit_latency", cyc, e.cyc);
        end
      end
    end
  end

  task automatic issue(input logic [20:0] addr, input logic [15:0] exp_data,
                       input logic exp_hit, input logic push);
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = addr;
    #1;
    check("req_ready", {31'h0, req_ready}, 32'h1);
    if (push) begin
      e.data = exp_data;
      e.hit  = exp_hit;
      e.cyc  = exp_hit ? cyc + 2 : -1;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (q.size() == 0) break;
      @(posedge clk);
      #2;
    end
    check("resp_drained", q.size(), 0);
    q.delete();
  endtask

  task automatic do_read(input logic [20:0] addr, input logic [15:0] exp_data, input logic exp_hit);
    issue(addr, exp_data, exp_hit, 1'b1);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int h0;
    int w0;
    reset = 1'b1;
    req_valid = 1'b0;
    req_addr = 21'h0;
    flush = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_req_ready", {31'h0, req_ready}, 32'h1);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_mem_req_valid", {31'h0, mem_req_valid}, 32'h0);
    check("rst_hit_count", {16'h0, hit_count}, 32'h0);
    check("rst_miss_count", {16'h0, miss_count}, 32'h0);

    // Cold miss
    h0 = hs_count;
    do_read(21'h00123, 16'hBEEF, 1'b0);
    check("cold_mem_addr", {11'h0, hs_addr}, 32'h00123);
    check("cold_hs", hs_count, h0 + 1);
    check("cold_we_tag", {30'h0, last_we_tag}, 32'h1);
    check("cold_we_data", {30'h0, last_we_data}, 32'h1);
    check("cold_we_set", {24'h0, last_we_set}, 32'h23);
    check("cold_miss_count", {16'h0, miss_count}, 32'h1);

    // Hit on the same address, no memory traffic
    h0 = hs_count;
    do_read(21'h00123, 16'hBEEF, 1'b1);
    check("hit_no_mem", hs_count, h0);
    check("hit_count_1", {16'h0, hit_count}, 32'h1);

    // Replacement in set 0x23
    do_read(21'h00223, 16'h1111, 1'b0);
    check("fill_tag1_way", {30'h0, last_we_tag}, 32'h2);
    do_read(21'h00123, 16'hBEEF, 1'b1);
    do_read(21'h00323, 16'h2222, 1'b0);
    check("lru_victim_way1", {30'h0, last_we_tag}, 32'h2);
    do_read(21'h00123, 16'hBEEF, 1'b1);
    do_read(21'h00223, 16'h1111, 1'b0);
    check("repl_hit_count", {16'h0, hit_count}, 32'h3);
    check("repl_miss_count", {16'h0, miss_count}, 32'h4);

    // Flush collides with a request: flush wins
    @(negedge clk);
    flush = 1'b1;
    req_valid = 1'b1;
    req_addr = 21'h00123;
    #1;
    check("flush_req_ready", {31'h0, req_ready}, 32'h0);
    check("flush_rd_en", {31'h0, way_rd_en}, 32'h0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    do_read(21'h00123, 16'hBEEF, 1'b0);
    check("flush_miss_count", {16'h0, miss_count}, 32'h5);

    // Memory backpressure: request held stable while not ready
    stall_cfg = 5;
    issue(21'h00455, 16'h5E0F, 1'b0, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check("stall_valid", {31'h0, mem_req_valid}, 32'h1);
      check("stall_addr", {11'h0, mem_addr}, 32'h00455);
    end
    drain();
    stall_cfg = 0;

    // Reset while waiting for memory: no write, no response, counters cleared
    h0 = hs_count;
    w0 = we_count;
    issue(21'h00777, 16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (hs_count != h0) break;
    end
    check("rst_hs_seen", hs_count, h0 + 1);
    reset = 1'b1;
    #1;
    check("rst_mw_we_tag", {30'h0, way_we_tag}, 32'h0);
    check("rst_mw_we_data", {30'h0, way_we_data}, 32'h0);
    @(posedge clk);
    #1;
    check("rst_mw_hit_count", {16'h0, hit_count}, 32'h0);
    check("rst_mw_miss_count", {16'h0, miss_count}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_mw_no_write", we_count, w0);
    check("rst_mw_resp_valid", {31'h0, resp_valid}, 32'h0);

    // Saturation of the hit counter
    do_read(21'h00123, 16'hBEEF, 1'b0);
    @(negedge clk);
    force dut.r_hit_count = 16'hFFFD;
    #1;
    release dut.r_hit_count;
    do_read(21'h00123, 16'hBEEF, 1'b1);
    check("sat_fffe", {16'h0, hit_count}, 32'hFFFE);
    do_read(21'h00123, 16'hBEEF, 1'b1);
    check("sat_ffff", {16'h0, hit_count}, 32'hFFFF);
    do_read(21'h00123, 16'hBEEF, 1'b1);
    check("sat_hold", {16'h0, hit_count}, 32'hFFFF);
    check("sat_miss_count", {16'h0, miss_count}, 32'h1);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
